// File: rtl/mxu_operand_loader.sv
// Operand feeder for the temporal MXU: streams a DIMxDIM A matrix then a B matrix
// (row-major), fires a one-cycle start, and holds both until the MXU signals done.
module mxu_operand_loader #(
  parameter int unsigned DIM       = 4,
  parameter int unsigned BIT_WIDTH = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [BIT_WIDTH-1:0]                       in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       mxu_done,
  output logic                                       start,
  output logic                                       busy,
  output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]     A,
  output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]     B
);

  localparam int unsigned NumElem  = DIM * DIM;
  localparam int unsigned CNT_BITS = $clog2(2 * NumElem);

  localparam logic [CNT_BITS-1:0] LastA = CNT_BITS'(NumElem - 1);
  localparam logic [CNT_BITS-1:0] LastB = CNT_BITS'(2 * NumElem - 1);

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StStart,
    StWait
  } state_e;

  state_e                                   state_q, state_d;
  logic [CNT_BITS-1:0]                      cnt_q, cnt_d;
  logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]   a_q, b_q;
  logic                                     accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoadA: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastA) state_d = StLoadB;
        end
      end
      StLoadB: begin
        // Hold the counter on the final accept so it never wraps.
        if (accept) begin
          if (cnt_q == LastB) begin
            state_d = StStart;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (mxu_done) begin
          state_d = StLoadA;
          cnt_d   = '0;
        end
      end
      default: state_d = StLoadA;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StLoadA: in_ready = 1'b1;
      StLoadB: in_ready = 1'b1;
      StStart: begin
        start = 1'b1;
        busy  = 1'b1;
      end
      StWait:  busy = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoadA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One write-enabled register per element; only the addressed element updates.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      localparam logic [CNT_BITS-1:0] IdxA = CNT_BITS'(r * DIM + c);
      localparam logic [CNT_BITS-1:0] IdxB = CNT_BITS'(NumElem + r * DIM + c);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q[r][c] <= '0;
        end else if (accept && (cnt_q == IdxA) && (state_q == StLoadA)) begin
          a_q[r][c] <= in_data;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          b_q[r][c] <= '0;
        end else if (accept && (cnt_q == IdxB) && (state_q == StLoadB)) begin
          b_q[r][c] <= in_data;
        end
      end
    end
  end

  assign A = a_q;
  assign B = b_q;

endmodule

// File: tb/tb_mxu_operand_loader.sv
// Self-checking bench for mxu_operand_loader: table-driven jobs, a start-time
// scoreboard of expected matrices, and hand-written reset corner cases.
module tb_mxu_operand_loader;

  typedef logic [3:0][3:0][3:0] mat_t;

  typedef struct {
    string name;
    mat_t  a;
    mat_t  b;
    int    gap_pct;
    bit    junk;
    bit    spur;
    int    wait_cycles;
    bit    do_done;
  } job_t;

  typedef struct {
    mat_t a;
    mat_t b;
  } exp_t;

  typedef struct {
    bit         is_b;
    int         r;
    int         c;
    logic [3:0] val;
  } spot_t;

  logic       clk;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mxu_done;
  logic       start;
  logic       busy;
  mat_t       dut_a;
  mat_t       dut_b;

  int   checks;
  int   passed;
  int   start_count;
  exp_t sb[$];

  mxu_operand_loader #(
    .DIM       (4),
    .BIT_WIDTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mxu_done (mxu_done),
    .start    (start),
    .busy     (busy),
    .A        (dut_a),
    .B        (dut_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_mat(input string name, input mat_t act, input mat_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard consumer: every start pulse must match the oldest queued job.
  always @(negedge clk) begin
    if (!reset && start === 1'b1) begin
      exp_t e;
      start_count++;
      if (sb.size() == 0) begin
        check_int("unexpected_start", 1, 0);
      end else begin
        e = sb.pop_front();
        check_mat("start_A", dut_a, e.a);
        check_mat("start_B", dut_b, e.b);
      end
    end
  end

  function automatic mat_t ramp_up();
    mat_t m;
    for (int k = 0; k < 16; k++) m[k/4][k%4] = 4'(k);
    return m;
  endfunction

  function automatic mat_t ramp_down();
    mat_t m;
    for (int k = 0; k < 16; k++) m[k/4][k%4] = 4'(15 - k);
    return m;
  endfunction

  task automatic run_job(input job_t j);
    int   k;
    int   cyc;
    int   starts0;
    bit   load_ok;
    bit   hold_ok;
    logic rdy;
    exp_t e;
    k       = 0;
    cyc     = 0;
    load_ok = 1'b1;
    hold_ok = 1'b1;
    starts0 = start_count;
    e.a     = j.a;
    e.b     = j.b;
    sb.push_back(e);
    while (k < 32 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      rdy = in_ready;
      if (in_ready !== 1'b1 || start !== 1'b0 || busy !== 1'b0) load_ok = 1'b0;
      in_valid = ($urandom_range(99) >= j.gap_pct);
      in_data  = (k < 16) ? j.a[k/4][k%4] : j.b[(k-16)/4][(k-16)%4];
      mxu_done = j.spur && (k == 5 || k == 20);
      @(posedge clk);
      if (in_valid && rdy) k++;
    end
    check_int({j.name, "_accepts"}, k, 32);
    check_bit({j.name, "_load_ready"}, load_ok, 1'b1);
    @(negedge clk);
    mxu_done = 1'b0;
    in_valid = j.junk;
    in_data  = 4'hF;
    check_bit({j.name, "_start_hi"}, start, 1'b1);
    check_bit({j.name, "_ready_lo"}, in_ready, 1'b0);
    check_bit({j.name, "_busy_start"}, busy, 1'b1);
    @(negedge clk);
    check_bit({j.name, "_start_lo"}, start, 1'b0);
    check_bit({j.name, "_busy_wait"}, busy, 1'b1);
    for (int w = 0; w < j.wait_cycles; w++) begin
      @(negedge clk);
      if (dut_a !== j.a || dut_b !== j.b || in_ready !== 1'b0 || busy !== 1'b1 ||
          start !== 1'b0) hold_ok = 1'b0;
    end
    check_bit({j.name, "_wait_hold"}, hold_ok, 1'b1);
    if (j.do_done) begin
      mxu_done = 1'b1;
      @(negedge clk);
      mxu_done = 1'b0;
      in_valid = 1'b0;
      check_bit({j.name, "_done_busy"}, busy, 1'b0);
      check_bit({j.name, "_done_ready"}, in_ready, 1'b1);
    end else begin
      in_valid = 1'b0;
    end
    check_int({j.name, "_start_once"}, start_count - starts0, 1);
  endtask

  job_t  jobs[4];
  spot_t spots[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mat_t rnd_a;
    mat_t rnd_b;
    job_t jw;
    checks      = 0;
    passed      = 0;
    start_count = 0;
    rnd_a       = {$urandom, $urandom};
    rnd_b       = {$urandom, $urandom};

    jobs[0] = '{"basic", ramp_up(), ramp_down(), 0, 0, 0, 3, 1};
    jobs[1] = '{"ones", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 0, 1, 0, 20, 1};
    jobs[2] = '{"bubbles", ramp_up(), ramp_down(), 40, 1, 0, 20, 1};
    jobs[3] = '{"spurious", rnd_a, rnd_b, 20, 0, 1, 2, 1};

    spots[0] = '{0, 2, 3, 4'd11};
    spots[1] = '{1, 0, 0, 4'd15};
    spots[2] = '{1, 3, 3, 4'd0};
    spots[3] = '{0, 0, 0, 4'd0};
    spots[4] = '{0, 3, 3, 4'd15};
    spots[5] = '{1, 1, 2, 4'd9};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    mxu_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_bit("rst_ready", in_ready, 1'b1);
    check_bit("rst_start", start, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_mat("rst_A", dut_a, '0);
    check_mat("rst_B", dut_b, '0);

    for (int i = 0; i < 4; i++) begin
      run_job(jobs[i]);
      if (i == 0) begin
        for (int s = 0; s < 6; s++) begin
          check_int("spot", int'(spots[s].is_b ? dut_b[spots[s].r][spots[s].c]
                                               : dut_a[spots[s].r][spots[s].c]),
                    int'(spots[s].val));
        end
      end
    end

    // Reset in the middle of LOAD_B.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (k < 16) ? jobs[3].a[k/4][k%4] : jobs[3].b[(k-16)/4][(k-16)%4];
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_mat("midb_rst_A", dut_a, '0);
    check_mat("midb_rst_B", dut_b, '0);
    check_bit("midb_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_bit("midb_rst_ready", in_ready, 1'b1);
    run_job(jobs[0]);

    // Reset while waiting for the MXU, then a stale done pulse.
    jw         = jobs[1];
    jw.name    = "abandon";
    jw.do_done = 1'b0;
    jw.wait_cycles = 4;
    run_job(jw);
    reset = 1'b1;
    #1;
    check_bit("wait_rst_start", start, 1'b0);
    check_bit("wait_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    mxu_done = 1'b1;
    @(negedge clk);
    mxu_done = 1'b0;
    check_bit("stale_done_busy", busy, 1'b0);
    check_bit("stale_done_ready", in_ready, 1'b1);
    check_bit("stale_done_start", start, 1'b0);
    run_job(jobs[2]);

    check_int("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mxu_operand_loader.md
# mxu_operand_loader

Upstream feeder for the temporal matrix-multiply unit. Accepts operand elements one at a time over a valid/ready stream and assembles a DIM×DIM A matrix followed by a DIM×DIM B matrix in local registers. When both are complete it issues a one-cycle `start` to the MXU and holds both matrices stable until the MXU reports completion. It then reopens the stream for the next job.

## Interface
- DIM, 4, matrix dimension; must be ≥2.
- BIT_WIDTH, 4, operand element width in bits.
- CNT_BITS, $clog2(2*DIM*DIM), element counter width; derived, not overridden.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  BIT_WIDTH  operand element.
- in_valid  input  1  in_data holds a valid element this cycle.
- in_ready  output  1  loader accepts an element this cycle.
- mxu_done  input  1  single-cycle completion pulse from the MXU. Generating it as a pulse is the integrator's job.
- start  output  1  one-cycle pulse; A/B are valid and the MXU may begin.
- busy  output  1  high from `start` until completion is acknowledged.
- A  output  [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]  A matrix, indexed A[row][col].
- B  output  [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]  B matrix, indexed B[row][col].

## Operation
- Handshake: an element is accepted on a rising edge where in_valid && in_ready.
- Element order is row-major, A first, then B:
  - counter values 0..DIM²-1 go to A[cnt/DIM][cnt%DIM];
  - counter values DIM²..2·DIM²-1 go to B[(cnt-DIM²)/DIM][(cnt-DIM²)%DIM].
- Only the addressed element is written; every other matrix element holds its value.
- The counter increments on each accepted element. It clears on the transition WAIT→LOAD_A. It never wraps during a load.
- State machine (Moore outputs):
  - LOAD_A: in_ready=1. The accept at cnt=DIM²-1 → LOAD_B.
  - LOAD_B: in_ready=1. The accept at cnt=2·DIM²-1 → START.
  - START: in_ready=0, start=1, busy=1. Unconditionally → WAIT.
  - WAIT: in_ready=0, busy=1, A/B frozen. mxu_done=1 → LOAD_A with cnt←0.
- mxu_done is ignored in LOAD_A, LOAD_B and START.
- In_valid while in_ready=0 has no effect. Data is not captured and the counter does not move.
- A/B are not cleared between jobs. Each new job overwrites every element before the next `start`.
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - state=LOAD_A, cnt=0;
  - A and B all zero;
  - start=0, busy=0, in_ready=1 once reset deasserts.
- Reset during WAIT abandons the job. A later mxu_done pulse is ignored, because the loader is then in LOAD_A.

## Timing
- in_ready, start and busy decode directly from the state register. There is no combinational path from in_valid or mxu_done to any output.
- A matrix element captured at edge t is visible on A/B after edge t.
- Last B element accepted at edge t:
  - start=1 and busy=1 during cycle t+1;
  - WAIT entered at edge t+1, so start=0 during cycle t+2.
- mxu_done high at edge u in WAIT:
  - busy=0 and in_ready=1 during cycle u+1;
  - the first element of the next job can be accepted at edge u+1.
- Minimum job period at full stream rate: 2·DIM² accept cycles + 1 START cycle + MXU latency + 1 cycle.
- start is asserted exactly once per job.

## Test plan
- Basic load, DIM=4, BIT_WIDTH=4: stream 32 elements with in_valid held high, A[i][j]=(4i+j), B[i][j]=15-(4i+j). Expected:
  - in_ready stays high for exactly 32 accepts, then drops;
  - start pulses for exactly one cycle, the cycle after the 32nd accept;
  - A[2][3]=11, B[0][0]=15, B[3][3]=0.
- Bubbles and backpressure: insert random in_valid gaps and drive in_valid=1 with in_data=0xF during START/WAIT. Expected: matrices match the Basic load case, the 0xF values are never captured, and cnt does not advance in WAIT.
- Completion: hold WAIT for 20 cycles, then pulse mxu_done. Expected:
  - A/B are unchanged during all 20 cycles;
  - busy falls and in_ready rises the cycle after the pulse;
  - a second job with A=all 1, B=all 2 produces exactly those matrices and a single new start.
- Spurious done: pulse mxu_done during LOAD_A (cnt=5) and during LOAD_B (cnt=20). Expected: no state change, the load continues, and start appears only after the 32nd element.
- Reset mid-LOAD_B: assert reset after 20 accepts. Expected:
  - A/B read zero immediately;
  - in_ready=1 after deassert;
  - a full 32-element reload produces start with the correct matrices.
- Reset in WAIT followed by mxu_done: expected start=0, busy=0, state LOAD_A, and the done pulse has no effect.
